// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states
// and the select/ALU-op codes consumed by the datapath and ALU decoder.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_SUB    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    localparam logic [1:0] SRC_A_PC      = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC   = 2'b01;
    localparam logic [1:0] SRC_A_RD1     = 2'b10;

    localparam logic [1:0] SRC_B_RD2     = 2'b00;
    localparam logic [1:0] SRC_B_IMM     = 2'b01;
    localparam logic [1:0] SRC_B_FOUR    = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // An instruction retires on the edge that leaves its final state.
    function automatic logic retires(input state_t s, input logic mem_ready);
        return (s == S_MEMWB) || (s == S_ALUWB) || (s == S_BEQ) ||
               ((s == S_MEMWRITE) && mem_ready);
    endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Combinational state-to-control decode for the main FSM. Strobes here are
// raw; the top gates them with reset.
module main_fsm_outdec
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal
);

    logic pc_update;
    logic branch;

    always_comb begin
        alu_op     = ALU_OP_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RD2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_READDATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_RD2;
                alu_op    = ALU_OP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            S_JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_update = 1'b1;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRC_A_RD1;
                alu_src_b = SRC_B_RD2;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
            end
            S_TRAP: illegal = 1'b1;
            default: ;
        endcase
        pc_write = pc_update | (branch & zero);
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction
// from its opcode, stalls on mem_ready and counts retired instructions.
//
//  state    | meaning
//  FETCH    | read instruction, PC <= PC+4 when memory ready
//  DECODE   | register read, branch target into ALU
//  MEMADR   | load/store address compute
//  MEMREAD  | data read, wait for memory
//  MEMWB    | load data -> register file
//  MEMWRITE | data write, wait for memory
//  EXEC_R   | register-register ALU op
//  EXEC_I   | register-immediate ALU op
//  JAL      | PC <= target, rd value = old PC + 4
//  ALUWB    | ALU result -> register file
//  BEQ      | compare, take branch on zero
//  TRAP     | unsupported opcode, parked until reset
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t state_next;

    logic ir_write_raw;
    logic pc_write_raw;
    logic reg_write_raw;
    logic mem_write_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state <= state_next;
            if (retires(state, mem_ready))
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_JAL:            state_next = S_JAL;
                    OP_BEQ:            state_next = S_BEQ;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    main_fsm_outdec u_outdec (
        .state      (state),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write_raw),
        .pc_write   (pc_write_raw),
        .reg_write  (reg_write_raw),
        .mem_write  (mem_write_raw),
        .illegal    (illegal)
    );

    // FETCH strobes follow mem_ready, so hold every strobe low while in reset.
    assign ir_write  = ir_write_raw  & rst_n;
    assign pc_write  = pc_write_raw  & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign mem_write = mem_write_raw & rst_n;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm with a 4-bit retired counter.
module tb_multicycle_main_fsm;

    typedef struct {
        logic [6:0] op;
        logic       zero;
        int         lat;
        int         regw;
        int         memw;
        int         pcw;
        logic [1:0] aop;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;
    logic [3:0] retired;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_ret = 4'd0;
    vec_t       sb[$];
    vec_t       vecs[7];

    multicycle_main_fsm #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .illegal    (illegal),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge while in FETCH with mem_ready=1; returns at the
    // negedge of the next FETCH.
    task automatic run_instr(input vec_t v);
        int         cyc;
        int         regw;
        int         memw;
        int         pcw;
        logic [1:0] aop;
        logic       done;
        vec_t       e;
        op   = v.op;
        zero = v.zero;
        sb.push_back(v);
        exp_ret = exp_ret + 4'd1;
        #1;
        cyc  = 1;
        regw = int'(reg_write);
        memw = int'(mem_write);
        pcw  = int'(pc_write);
        aop  = alu_op;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ir_write) done = 1'b1;
            else begin
                cyc++;
                regw += int'(reg_write);
                memw += int'(mem_write);
                pcw  += int'(pc_write);
                aop  |= alu_op;
            end
        end
        e = sb.pop_front();
        check("instr_completes", 32'(done), 32'd1);
        check("latency",   32'(cyc),  32'(e.lat));
        check("reg_write_count", 32'(regw), 32'(e.regw));
        check("mem_write_count", 32'(memw), 32'(e.memw));
        check("pc_write_count",  32'(pcw),  32'(e.pcw));
        check("alu_op_seen", 32'(aop), 32'(e.aop));
        check("retired",   32'(retired), 32'(exp_ret));
    endtask

    initial begin
        int strobes;
        int not_illegal;
        vec_t add_v;

        //        op          z     lat regw memw pcw aop
        vecs[0] = '{7'b0110011, 1'b0, 4, 1, 0, 1, 2'b10};
        vecs[1] = '{7'b0010011, 1'b0, 4, 1, 0, 1, 2'b10};
        vecs[2] = '{7'b0000011, 1'b0, 5, 1, 0, 1, 2'b00};
        vecs[3] = '{7'b0100011, 1'b0, 4, 0, 1, 1, 2'b00};
        vecs[4] = '{7'b1101111, 1'b0, 4, 1, 0, 2, 2'b00};
        vecs[5] = '{7'b1100011, 1'b1, 3, 0, 0, 2, 2'b01};
        vecs[6] = '{7'b1100011, 1'b0, 3, 0, 0, 1, 2'b01};
        add_v   = vecs[0];

        rst_n = 1'b0; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ir_write",  32'(ir_write),  32'd0);
        check("rst_pc_write",  32'(pc_write),  32'd0);
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        check("rst_retired",   32'(retired),   32'd0);
        check("rst_src_b",     32'(alu_src_b), 32'd2);
        check("rst_res_src",   32'(result_src), 32'd2);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_fetch_ir_write", 32'(ir_write), 32'd1);

        for (int i = 0; i < 7; i++) run_instr(vecs[i]);

        // lw with memory stalled in MEMREAD
        op = 7'b0000011; exp_ret = exp_ret + 4'd1;
        #1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("memread_adr_src", 32'(adr_src), 32'd1);
            check("memread_no_regw", 32'(reg_write), 32'd0);
            if (k == 3) mem_ready = 1'b1;
        end
        @(negedge clk);
        check("memwb_reg_write", 32'(reg_write),  32'd1);
        check("memwb_res_src",   32'(result_src), 32'd1);
        @(negedge clk);
        check("lw_back_in_fetch", 32'(ir_write), 32'd1);
        check("lw_retired",       32'(retired),  32'(exp_ret));

        // unsupported opcode parks in TRAP
        op = 7'b0000000;
        #1;
        @(negedge clk);
        strobes = 0; not_illegal = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            strobes     += int'(ir_write | pc_write | reg_write | mem_write);
            not_illegal += int'(!illegal);
        end
        check("trap_strobes",  32'(strobes),     32'd0);
        check("trap_illegal",  32'(not_illegal), 32'd0);
        check("trap_retired",  32'(retired),     32'(exp_ret));
        #2 rst_n = 1'b0;
        #1;
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        check("trap_rst_retired", 32'(retired), 32'd0);
        exp_ret = 4'd0;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;

        // reset pulse while a store waits on memory
        op = 7'b0100011;
        #1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        check("sw_mem_write", 32'(mem_write), 32'd1);
        check("sw_adr_src",   32'(adr_src),   32'd1);
        #2 rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        check("sw_rst_mem_write", 32'(mem_write), 32'd0);
        check("sw_rst_adr_src",   32'(adr_src),   32'd0);
        check("sw_rst_ir_write",  32'(ir_write),  32'd0);
        check("sw_rst_retired",   32'(retired),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sw_rst_fetch", 32'(ir_write), 32'd1);

        // counter wrap: 15 then 16 instructions
        for (int k = 0; k < 15; k++) run_instr(add_v);
        check("retired_max", 32'(retired), 32'd15);
        run_instr(add_v);
        check("retired_wrap", 32'(retired), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
